i4002_host_seq: RTL and testbench

Host-side sequencer for the 4002 RAM bus. Converts single-nibble host read/write requests into legal MCS-4 instruction-cycle sequences and drives the RAM-facing `sync`, `cm_ram` and data lines. It generates the free-running 8-slot frame (A1..X3) itself. It sits between the PYNQ-side register interface and one bank of up to four i4002 chips, and is used when the i4004 is absent or halted.

---
 rtl/i4002_host_seq.sv | 132 +++++++++++++
 tb/tb_i4002_host_seq.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/i4002_host_seq.sv
// Host-side 4002 RAM bus sequencer: runs the 8-slot MCS-4 frame and turns one
// host nibble request into an SRC frame, an I/O frame and an optional read-drain frame.
module i4002_host_seq #(
  parameter bit READ_DRAIN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [3:0] req_op,
  input  logic [1:0] req_chip,
  input  logic [1:0] req_reg,
  input  logic [3:0] req_char,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  output logic       rsp_err,
  output logic [3:0] rsp_rdata,
  output logic       busy,
  output logic       sync,
  output logic       cm_ram,
  output logic [3:0] ram_dbus_wr,
  input  logic [3:0] ram_dbus_rd
);

  localparam logic [3:0] OP_WRM = 4'h0, OP_WMP = 4'h1, OP_SBM = 4'h8,
                         OP_RDM = 4'h9, OP_ADM = 4'hB;

  typedef enum logic [1:0] {S_IDLE, S_SRC, S_IO, S_DRAIN} state_e;

  state_e     state_q;
  logic [2:0] slot_q;
  logic       primed_q;
  logic [3:0] op_q, char_q, wdata_q;
  logic [1:0] chip_q, reg_q;
  logic       rsp_valid_q, rsp_err_q;
  logic [3:0] rsp_rdata_q;

  // WR0..WR3 are 01xx, RD0..RD3 are 11xx
  function automatic logic op_is_wr(input logic [3:0] op);
    return (op == OP_WRM) || (op == OP_WMP) || (op[3:2] == 2'b01);
  endfunction

  function automatic logic op_is_rd(input logic [3:0] op);
    return (op == OP_SBM) || (op == OP_RDM) || (op == OP_ADM) || (op[3:2] == 2'b11);
  endfunction

  logic accept, fin6;
  assign req_ready = primed_q && (slot_q == 3'd7) && (state_q == S_IDLE);
  assign accept    = req_valid && req_ready;
  // Slot 6 of whichever frame ends the operation: sample and raise the response
  assign fin6 = (slot_q == 3'd6) &&
                (((state_q == S_IO) && (op_is_wr(op_q) || !READ_DRAIN)) ||
                 (state_q == S_DRAIN));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      slot_q      <= 3'd0;
      primed_q    <= 1'b0;
      op_q        <= 4'd0;
      char_q      <= 4'd0;
      wdata_q     <= 4'd0;
      chip_q      <= 2'd0;
      reg_q       <= 2'd0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= 4'd0;
    end else begin
      slot_q      <= slot_q + 3'd1;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      if (slot_q == 3'd7) primed_q <= 1'b1;
      unique case (state_q)
        S_IDLE: if (accept) begin
          if (op_is_wr(req_op) || op_is_rd(req_op)) begin
            op_q    <= req_op;
            chip_q  <= req_chip;
            reg_q   <= req_reg;
            char_q  <= req_char;
            wdata_q <= req_wdata;
            state_q <= S_SRC;
          end else begin
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 4'd0;
          end
        end
        S_SRC:   if (slot_q == 3'd7) state_q <= S_IO;
        S_IO:    if (slot_q == 3'd7)
                   state_q <= (op_is_rd(op_q) && READ_DRAIN) ? S_DRAIN : S_IDLE;
        S_DRAIN: if (slot_q == 3'd7) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
      if (fin6) begin
        rsp_valid_q <= 1'b1;
        rsp_rdata_q <= op_is_wr(op_q) ? 4'd0 : ram_dbus_rd;
      end
    end
  end

  // Bus lines decode from registered state only; host inputs never reach them
  always_comb begin
    cm_ram      = 1'b0;
    ram_dbus_wr = 4'd0;
    unique case (state_q)
      S_SRC: begin
        if (slot_q == 3'd6) begin
          cm_ram      = 1'b1;
          ram_dbus_wr = {chip_q, reg_q};
        end else if (slot_q == 3'd7) begin
          ram_dbus_wr = char_q;
        end
      end
      S_IO: begin
        if (slot_q == 3'd4) begin
          cm_ram      = 1'b1;
          ram_dbus_wr = op_q;
        end else if (slot_q == 3'd6) begin
          ram_dbus_wr = op_is_wr(op_q) ? wdata_q : 4'd0;
        end
      end
      default: ;
    endcase
  end

  assign sync      = (slot_q == 3'd7);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_i4002_host_seq.sv
// Bench for i4002_host_seq: instance 0 uses READ_DRAIN=1, instance 1 READ_DRAIN=0,
// each on its own 4002 bus model (chip ID 2), checked against an array reference.
module tb_i4002_host_seq;

  localparam logic [3:0] OP_WRM = 4'h0, OP_WMP = 4'h1, OP_WRR = 4'h2, OP_WPM = 4'h3,
                         OP_WR0 = 4'h4, OP_WR1 = 4'h5, OP_WR2 = 4'h6, OP_WR3 = 4'h7,
                         OP_SBM = 4'h8, OP_RDM = 4'h9, OP_RDR = 4'hA, OP_ADM = 4'hB,
                         OP_RD0 = 4'hC, OP_RD1 = 4'hD, OP_RD2 = 4'hE, OP_RD3 = 4'hF;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_op = 4'd0, req_char = 4'd0, req_wdata = 4'd0;
  logic [1:0] req_chip = 2'd0, req_reg = 2'd0;

  logic       rdy [2];
  logic       rv  [2];
  logic       re  [2];
  logic [3:0] rd  [2];
  logic       bsy [2];
  logic       sy  [2];
  logic       cm  [2];
  logic [3:0] dw  [2];
  logic [3:0] dr  [2];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference contents of chip 2: main characters and status characters
  logic [3:0] ref_mem [4][16] = '{default: '0};
  logic [3:0] ref_st  [4][4]  = '{default: '0};

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit is_wr(input logic [3:0] op);
    return op inside {OP_WRM, OP_WMP, OP_WR0, OP_WR1, OP_WR2, OP_WR3};
  endfunction

  function automatic bit is_rd(input logic [3:0] op);
    return op inside {OP_SBM, OP_RDM, OP_ADM, OP_RD0, OP_RD1, OP_RD2, OP_RD3};
  endfunction

  for (genvar g = 0; g < 2; g++) begin : gi
    i4002_host_seq #(.READ_DRAIN(g == 0)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(rdy[g]), .req_op(req_op), .req_chip(req_chip),
      .req_reg(req_reg), .req_char(req_char), .req_wdata(req_wdata),
      .rsp_valid(rv[g]), .rsp_err(re[g]), .rsp_rdata(rd[g]), .busy(bsy[g]),
      .sync(sy[g]), .cm_ram(cm[g]), .ram_dbus_wr(dw[g]), .ram_dbus_rd(dr[g])
    );

    // 4002 bus model, chip ID 2; read data is presented at X2 of the I/O frame and the next one
    logic [2:0] ms;
    logic       sel, pch, iop;
    logic [1:0] mreg, rcnt;
    logic [3:0] mchr, mop, rdv;
    logic [3:0] mm [4][16] = '{default: '0};
    logic [3:0] st [4][4]  = '{default: '0};

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ms <= 3'd0; sel <= 1'b0; pch <= 1'b0; iop <= 1'b0;
        mreg <= 2'd0; rcnt <= 2'd0; mchr <= 4'd0; mop <= 4'd0; rdv <= 4'd0;
      end else begin
        ms <= sy[g] ? 3'd0 : ms + 3'd1;
        if (ms == 3'd6 && cm[g]) begin
          sel  <= (dw[g][3:2] == 2'd2);
          mreg <= dw[g][1:0];
          pch  <= 1'b1;
        end
        if (ms == 3'd7 && pch) begin
          mchr <= dw[g];
          pch  <= 1'b0;
        end
        if (ms == 3'd4 && cm[g] && sel) begin
          mop <= dw[g];
          iop <= 1'b1;
          if (is_rd(dw[g])) begin
            rdv  <= (dw[g][3:2] == 2'b11) ? st[mreg][dw[g][1:0]] : mm[mreg][mchr];
            rcnt <= 2'd2;
          end
        end
        if (ms == 3'd6 && iop) iop <= 1'b0;
        if (ms == 3'd7 && rcnt != 2'd0) rcnt <= rcnt - 2'd1;
      end
    end

    always @(posedge clk) begin
      if (ms == 3'd6 && iop) begin
        if (mop == OP_WRM) mm[mreg][mchr] <= dw[g];
        else if (mop[3:2] == 2'b01) st[mreg][mop[1:0]] <= dw[g];
      end
    end

    assign dr[g] = (ms == 3'd6 && rcnt != 2'd0) ? rdv : 4'd0;
  end

  // Called at a negedge: asserts reset at once, then releases and checks priming.
  // req_valid is held high with an unsupported opcode throughout.
  task automatic do_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_op = OP_WRR;
    #1;
    for (int i = 0; i < 2; i++)
      chk($sformatf("reset_outs%0d", i),
          {sy[i], cm[i], dw[i], rdy[i], rv[i], re[i], rd[i], bsy[i]}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      if (c > 1) @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("sync%0d_c%0d", i, c), sy[i], (c % 8) == 0);
        chk($sformatf("ready%0d_c%0d", i, c), rdy[i], (c == 16) || (c == 24));
        chk($sformatf("rsp%0d_c%0d", i, c), {rv[i], re[i], bsy[i]}, (c == 17) ? 3'b110 : 3'b000);
      end
      if (c == 24) req_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((bsy[0] || bsy[1]) && k < 64) begin @(negedge clk); k++; end
    chk("idle_wait", {bsy[0], bsy[1]}, 2'b00);
  endtask

  // Raise a request and wait for the accept edge; returns at the accepting negedge
  task automatic issue(input logic [3:0] op, input logic [1:0] chip, rg,
                       input logic [3:0] ch, wd);
    int k = 0;
    wait_idle();
    req_op = op; req_chip = chip; req_reg = rg; req_char = ch; req_wdata = wd;
    req_valid = 1'b1;
    while (!(rdy[0] || rdy[1]) && k < 16) begin @(negedge clk); k++; end
    chk("accept", {rdy[0], rdy[1]}, 2'b11);
  endtask

  task automatic scramble();
    req_valid = 1'b0;
    req_op = 4'($urandom); req_chip = 2'($urandom); req_reg = 2'($urandom);
    req_char = 4'($urandom); req_wdata = 4'($urandom);
  endtask

  task automatic do_op(input logic [3:0] op, input logic [1:0] chip, rg,
                       input logic [3:0] ch, wd);
    bit          err = !(is_wr(op) || is_rd(op));
    logic [3:0]  exp_rd = 4'd0;
    logic [3:0]  ew;
    logic [31:0] m_cm [2], m_bsy [2], m_rv [2];
    logic [31:0] e_cm, e_bsy, e_rv;
    int          nwr [2];
    int          lat;
    logic [3:0]  io6 [2], got_rd [2];
    logic        got_err [2];

    issue(op, chip, rg, ch, wd);
    if (is_rd(op) && chip == 2'd2)
      exp_rd = (op[3:2] == 2'b11) ? ref_st[rg][op[1:0]] : ref_mem[rg][ch];
    if (is_wr(op) && chip == 2'd2) begin
      if (op == OP_WRM) ref_mem[rg][ch] = wd;
      else if (op inside {OP_WR0, OP_WR1, OP_WR2, OP_WR3}) ref_st[rg][op - OP_WR0] = wd;
    end
    for (int i = 0; i < 2; i++) begin
      m_cm[i] = '0; m_bsy[i] = '0; m_rv[i] = '0; nwr[i] = 0;
      io6[i] = 4'd0; got_rd[i] = 4'hx; got_err[i] = 1'bx;
    end
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      ew = 4'd0;
      if (!err)
        case (k)
          7:  ew = {chip, rg};
          8:  ew = ch;
          13: ew = op;
          15: ew = is_wr(op) ? wd : 4'd0;
          default: ew = 4'd0;
        endcase
      for (int i = 0; i < 2; i++) begin
        m_cm[i][k] = cm[i]; m_bsy[i][k] = bsy[i]; m_rv[i][k] = rv[i];
        if (rv[i]) begin got_rd[i] = rd[i]; got_err[i] = re[i]; end
        if (dw[i] !== ew) nwr[i]++;
        if (k == 15) io6[i] = dr[i];
      end
      if (k == 1) scramble();
    end
    for (int i = 0; i < 2; i++) begin
      lat   = err ? 1 : ((is_rd(op) && i == 0) ? 24 : 16);
      e_rv  = 32'd1 << lat;
      e_bsy = err ? 32'd0 : ((32'd1 << (lat + 1)) - 32'd2);
      e_cm  = err ? 32'd0 : ((32'd1 << 7) | (32'd1 << 13));
      chk($sformatf("rsp_timing%0d op%0h", i, op), m_rv[i], e_rv);
      chk($sformatf("busy%0d op%0h", i, op), m_bsy[i], e_bsy);
      chk($sformatf("cm_ram%0d op%0h", i, op), m_cm[i], e_cm);
      chk($sformatf("dbus_wr_bad_slots%0d op%0h", i, op), nwr[i], 0);
      chk($sformatf("rsp_err%0d op%0h", i, op), got_err[i], err);
      chk($sformatf("rsp_rdata%0d op%0h", i, op), got_rd[i], is_rd(op) ? exp_rd : 4'd0);
    end
    if (is_rd(op)) chk("rdata_vs_io_slot6", got_rd[1], io6[1]);
  endtask

  task automatic drop_req();
    int k = 0;
    bit hit [2];
    wait_idle();
    while (!sy[0] && k < 16) begin @(negedge clk); k++; end
    @(negedge clk);
    req_op = OP_WRM; req_chip = 2'd2; req_reg = 2'd0; req_char = 4'd0; req_wdata = 4'hE;
    req_valid = 1'b1;
    repeat (4) @(negedge clk);
    req_valid = 1'b0;
    hit[0] = 1'b0; hit[1] = 1'b0;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (bsy[i] || rv[i] || cm[i]) hit[i] = 1'b1;
    end
    for (int i = 0; i < 2; i++) chk($sformatf("dropped_req%0d", i), hit[i], 1'b0);
  endtask

  task automatic reset_mid_write();
    issue(OP_WRM, 2'd2, 2'd3, 4'h6, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 1) scramble();
    end
    do_reset();
  endtask

  initial begin
    logic [3:0] op;
    logic [1:0] chip;
    @(negedge clk);
    do_reset();
    do_op(OP_WRM, 2'd2, 2'd1, 4'hA, 4'h5);
    do_op(OP_RDM, 2'd2, 2'd1, 4'hA, 4'h0);
    do_op(OP_WR3, 2'd2, 2'd1, 4'h0, 4'hC);
    do_op(OP_RD3, 2'd2, 2'd1, 4'h0, 4'h0);
    do_op(OP_RD3, 2'd2, 2'd2, 4'h0, 4'h0);
    do_op(OP_WRR, 2'd2, 2'd1, 4'h0, 4'h0);
    do_op(OP_RDR, 2'd1, 2'd0, 4'h0, 4'h0);
    drop_req();
    do_op(OP_WRM, 2'd2, 2'd3, 4'h6, 4'h3);
    reset_mid_write();
    do_op(OP_RDM, 2'd2, 2'd3, 4'h6, 4'h0);
    for (int n = 0; n < 60; n++) begin
      op   = 4'($urandom);
      chip = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'd2;
      do_op(op, chip, 2'($urandom), 4'($urandom_range(0, 3)), 4'($urandom));
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
